// File: rtl/pc_sequencer.sv
// Program-counter stage: sequential/branch/JAL/JALR next-PC selection with a
// redirect pulse, a fixed-length fetch-flush window and a sticky misalignment halt.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        instr_valid,
  input  logic        taken,
  input  logic [31:0] rs1_val,
  input  logic        stall,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        redirect,
  output logic        flush,
  output logic        fault,
  output logic [31:0] retired
);

  localparam int unsigned CW = 3;
  localparam logic [CW-1:0] FLUSH_LOAD = CW'(FLUSH_CYCLES);

  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_FLUSH = 2'd1;
  localparam logic [1:0] S_HALT  = 2'd2;

  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  logic [1:0]    state, state_next;
  logic [31:0]   pc_next, retired_next;
  logic          fault_next;
  logic [CW-1:0] cnt, cnt_next;

  logic [6:0]  opcode;
  logic [31:0] imm_b, imm_j, imm_i, target;
  logic        is_ctrl, accept;

  // Sign-extended RV32I immediates and the control-transfer target
  assign opcode = instr[6:0];
  assign imm_b  = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_j  = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
  assign imm_i  = {{20{instr[31]}}, instr[31:20]};

  always_comb begin
    target = pc + imm_b;
    if (opcode == OP_JAL)
      target = pc + imm_j;
    else if (opcode == OP_JALR)
      target = (rs1_val + imm_i) & ~32'd1;
  end

  assign is_ctrl  = (opcode == OP_B) || (opcode == OP_JAL) || (opcode == OP_JALR);
  assign accept   = (state == S_RUN) && instr_valid && !stall;
  assign pc_plus4 = pc + 32'd4;

  // Next-state and next-value logic
  always_comb begin
    state_next   = state;
    pc_next      = pc;
    retired_next = retired;
    fault_next   = fault;
    cnt_next     = cnt;
    redirect     = 1'b0;
    unique case (state)
      S_RUN: begin
        if (accept) begin
          if (taken && is_ctrl) begin
            if (target[1:0] == 2'b00) begin
              pc_next      = target;
              redirect     = 1'b1;
              retired_next = retired + 32'd1;
              if (FLUSH_LOAD != '0) begin
                state_next = S_FLUSH;
                cnt_next   = FLUSH_LOAD;
              end
            end else begin
              fault_next = 1'b1;
              state_next = S_HALT;
            end
          end else begin
            pc_next      = pc_plus4;
            retired_next = retired + 32'd1;
          end
        end
      end
      S_FLUSH: begin
        // Counter hits zero on this edge when it currently reads one
        cnt_next = cnt - CW'(1);
        if (cnt <= CW'(1)) begin
          state_next = S_RUN;
          cnt_next   = '0;
        end
      end
      S_HALT: begin
        state_next = S_HALT;
      end
      default: begin
        state_next = S_RUN;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_RUN;
      pc      <= RESET_PC;
      retired <= '0;
      fault   <= 1'b0;
      flush   <= 1'b0;
      cnt     <= '0;
    end else begin
      state   <= state_next;
      pc      <= pc_next;
      retired <= retired_next;
      fault   <= fault_next;
      flush   <= (state_next == S_FLUSH);
      cnt     <= cnt_next;
    end
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter stage that consumes the `taken` decision produced by the branch-condition checker and the instruction it was evaluated on. It computes the next PC for sequential flow, conditional branches (B-type), JAL and JALR. It issues a redirect pulse and a programmable fetch-flush window on every control transfer. Misaligned targets raise a sticky fault that halts sequencing until reset. It sits between fetch and the branch checker and drives the fetch address.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset; must be 4-byte aligned.
- `FLUSH_CYCLES`, default 1: bubble cycles after a redirect; legal range 0..7.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `instr`  in  32  instruction at the current `pc` (the same word fed to the branch checker).
- `instr_valid`  in  1  `instr` is valid this cycle.
- `taken`  in  1  branch/jump decision from the branch checker for `instr`.
- `rs1_val`  in  32  rs1 operand; used only for JALR.
- `stall`  in  1  hold request from downstream.
- `pc`  out  32  registered fetch address.
- `pc_plus4`  out  32  combinational `pc + 4`, used for the link register.
- `redirect`  out  1  combinational; high in the cycle a control transfer is accepted.
- `flush`  out  1  registered; high while in FLUSH.
- `fault`  out  1  registered, sticky; misaligned target.
- `retired`  out  32  registered count of accepted instructions; wraps.

## Operation
- States:
  - RUN: normal sequencing.
  - FLUSH: bubble window, held for `FLUSH_CYCLES` cycles.
  - HALT: terminal until reset.
- Reset (async, any state, mid-flush included) clears everything immediately: `pc=RESET_PC`, state RUN, `flush=0`, `fault=0`, `retired=0`, flush counter 0.
- Accept condition: state RUN && `instr_valid` && !`stall`.
- Immediates are sign-extended per RV32I:
  - immB = {instr[31],instr[7],instr[30:25],instr[11:8],0}
  - immJ = {instr[31],instr[19:12],instr[20],instr[30:21],0}
  - immI = instr[31:20]
- Control opcodes: 1100011 (B), 1101111 (JAL), 1100111 (JALR).
- Target:
  - B: `pc + immB`
  - JAL: `pc + immJ`
  - JALR: `(rs1_val + immI) & ~1`
  - All arithmetic is modulo 2^32.
- On accept:
  - If `taken` && opcode is a control opcode && target[1:0]==0: `pc<=target`, `redirect=1`, `retired++`. Enter FLUSH if `FLUSH_CYCLES>0`; otherwise stay in RUN.
  - If `taken` && opcode is a control opcode && target[1:0]!=0: `pc` held, `retired` not incremented, `fault<=1`, enter HALT, `redirect=0`.
  - Otherwise, including `taken` with a non-control opcode: `pc<=pc+4`, `retired++`.
- No accept in RUN: all state held.
- FLUSH:
  - `instr_valid`, `taken` and `stall` are ignored; `pc` is held.
  - The counter is loaded with `FLUSH_CYCLES` on entry and decrements every cycle, independent of `stall`.
  - Return to RUN when the counter reaches 0.
- HALT: `pc`, `retired` and `fault` are frozen; `redirect=0`; exit only via reset.

## Timing
- Next-PC latency: 1 cycle. `pc` updates on the edge that ends the accept cycle.
- `redirect` is asserted in the same cycle as accept; `flush` rises on the following edge.
- With `FLUSH_CYCLES=N`, `flush` stays high for exactly N cycles, then the first new accept is possible. A taken transfer therefore costs N+1 cycles.
- `fault` goes high on the edge after the faulting accept.
- `retired` wraps from 0xFFFF_FFFF to 0.
- `pc` wraps modulo 2^32 (e.g. `pc` 0xFFFF_FFFC, not taken → 0x0000_0000).

## Test plan
- Reset, then 3 non-control instructions (instr=0x00000013) accepted → `pc` 0x0→0x4→0x8→0xC, `retired`=3, `redirect`=0 throughout.
- `pc`=0x100, instr=0x00000863 (BEQ, imm +16), `taken`=1 → `redirect`=1 that cycle; `pc`=0x110 next edge; `flush` high 1 cycle. Same instr with `taken`=0 → `pc`=0x104.
- instr=0x0200006F (JAL +0x20) at 0x40 → `pc`=0x60. Then instr=0x00300067 (JALR imm 3), `rs1_val`=0x201 → `pc`=0x204.
- JALR imm 2, `rs1_val`=0x200 → target 0x202. Expect `fault`=1, `pc` held, `retired` unchanged, HALT persists 10 cycles. Reset → `pc`=RESET_PC, `fault`=0.
- `stall`=1 for 3 cycles with a taken branch presented → `pc`/`retired` held. Release → redirect occurs.
- `FLUSH_CYCLES`=2: taken branch → `flush` high exactly 2 cycles, `instr_valid` ignored during the window. Assert `reset` mid-flush → `flush`=0 and `pc`=RESET_PC immediately, without waiting for a clock edge.
